// File: rtl/remote_io_bridge_pkg.sv
// Shared definitions for the remote I/O bridge: 7-segment bit positions
// and the hex-digit segment table.
package remote_io_bridge_pkg;

    // Segment byte layout, 1 = lit
    localparam int SEG_M  = 7;
    localparam int SEG_LT = 6;
    localparam int SEG_T  = 5;
    localparam int SEG_RT = 4;
    localparam int SEG_LB = 3;
    localparam int SEG_B  = 2;
    localparam int SEG_RB = 1;
    localparam int SEG_DP = 0;

    // Pattern shown for digit '0' with the point off; also the display reset value
    localparam logic [7:0] SEG_ZERO = 8'h7E;

    // Hex digit to segment byte, decimal point cleared
    function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
        logic [7:0] seg;
        case (value)
            4'h0: seg = 8'h7E;
            4'h1: seg = 8'h12;
            4'h2: seg = 8'hBC;
            4'h3: seg = 8'hB6;
            4'h4: seg = 8'hD2;
            4'h5: seg = 8'hE6;
            4'h6: seg = 8'hEE;
            4'h7: seg = 8'h32;
            4'h8: seg = 8'hFE;
            4'h9: seg = 8'hF6;
            4'hA: seg = 8'hFA;
            4'hB: seg = 8'hCE;
            4'hC: seg = 8'h6C;
            4'hD: seg = 8'h9E;
            4'hE: seg = 8'hEC;
            default: seg = 8'hE8;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/remote_io_bridge_seg7.sv
// Combinational hex digit + decimal point to 7-segment byte encoder.
module seg7_encode
    import remote_io_bridge_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table lookup for the digit, then overlay the decimal point bit
    always_comb begin
        seg         = hex_to_seg(hex);
        seg[SEG_DP] = dp;
    end

endmodule

// File: rtl/remote_io_bridge.sv
// Registered bridge between remote board I/O pins and the local CPU side:
// debounced switches, stretched reset, registered LEDs and a scanned
// multi-digit hex display.
module remote_io_bridge
    import remote_io_bridge_pkg::*;
#(
    parameter int SW_W      = 8,
    parameter int LED_W     = 16,
    parameter int NUM_DIG   = 8,
    parameter int DB_TICK   = 1000,
    parameter int SCAN_TICK = 500,
    parameter int RST_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          remote_switch,
    output logic [SW_W-1:0]      local_switch,
    output logic                 local_sw_chg,
    input  logic [LED_W-1:0]     local_leds,
    output logic [LED_W-1:0]     remote_leds,
    input  logic                 remote_reset,
    output logic                 local_resetn,
    input  logic [4*NUM_DIG-1:0] local_num_data,
    input  logic [NUM_DIG-1:0]   local_num_dp,
    input  logic                 local_num_we,
    output logic [NUM_DIG-1:0]   remote_dig_sel,
    output logic [7:0]           remote_seg
);

    localparam int DB_W   = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;
    localparam int SCAN_W = (SCAN_TICK > 1) ? $clog2(SCAN_TICK) : 1;
    localparam int IDX_W  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_TICK - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICK - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIG - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    // Only the low SW_W switch bits are bridged; the rest are intentionally ignored
    logic unused_switch_bits;
    assign unused_switch_bits = ^remote_switch;

    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;
    logic [SW_W-1:0]   sw_prev;
    logic [DB_W-1:0]   db_cnt;
    logic              db_tick;
    logic              rr_meta;
    logic              rr_sync;
    logic [HOLD_W-1:0] hold_cnt;
    logic [4*NUM_DIG-1:0] num_data_q;
    logic [NUM_DIG-1:0]   num_dp_q;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  dig_idx;
    logic [3:0]        cur_hex;
    logic              cur_dp;
    logic [NUM_DIG-1:0] dig_sel_next;
    logic [7:0]        seg_next;

    // Two-flop synchroniser; switches are active-low on the pins, inverted here
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= ~remote_switch[SW_W-1:0];
            sw_sync <= sw_meta;
        end
    end

    // Debounce prescaler, ticks once every DB_TICK cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign db_tick = (db_cnt == DB_LAST);

    // Accept a switch value only when two consecutive ticks agree on it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_prev      <= '0;
            local_switch <= '0;
            local_sw_chg <= 1'b0;
        end else begin
            local_sw_chg <= 1'b0;
            if (db_tick) begin
                sw_prev <= sw_sync;
                if ((sw_sync == sw_prev) && (sw_sync != local_switch)) begin
                    local_switch <= sw_sync;
                    local_sw_chg <= 1'b1;
                end
            end
        end
    end

    // LED pins are active-low, registered for one cycle of latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            remote_leds <= '1;
        end else begin
            remote_leds <= ~local_leds;
        end
    end

    // Two-flop synchroniser for the remote reset button
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_meta <= 1'b0;
            rr_sync <= 1'b0;
        end else begin
            rr_meta <= remote_reset;
            rr_sync <= rr_meta;
        end
    end

    // Hold local reset low until RST_HOLD quiet cycles have passed; released from a register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_cnt     <= '0;
            local_resetn <= 1'b0;
        end else if (rr_sync) begin
            hold_cnt     <= '0;
            local_resetn <= 1'b0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt     <= hold_cnt + 1'b1;
            local_resetn <= (hold_cnt == HOLD_LAST);
        end else begin
            local_resetn <= 1'b1;
        end
    end

    // Display latch, only updated on the capture strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            num_data_q <= '0;
            num_dp_q   <= '0;
        end else if (local_num_we) begin
            num_data_q <= local_num_data;
            num_dp_q   <= local_num_dp;
        end
    end

    // Scan timer and digit index, the index advances when the timer wraps
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit mux: select nibble, point and one-hot enable from the same index
    always_comb begin
        cur_hex      = 4'h0;
        cur_dp       = 1'b0;
        dig_sel_next = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (dig_idx == IDX_W'(i)) begin
                cur_hex         = num_data_q[4*i +: 4];
                cur_dp          = num_dp_q[i];
                dig_sel_next[i] = 1'b1;
            end
        end
    end

    seg7_encode u_seg7_encode (
        .hex (cur_hex),
        .dp  (cur_dp),
        .seg (seg_next)
    );

    // Enable and segment byte are registered together so they never disagree
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            remote_dig_sel <= NUM_DIG'(1);
            remote_seg     <= SEG_ZERO;
        end else begin
            remote_dig_sel <= dig_sel_next;
            remote_seg     <= seg_next;
        end
    end

endmodule

// File: tb/tb_remote_io_bridge.sv
// Self-checking bench for remote_io_bridge with small timing parameters.
module tb_remote_io_bridge;

    localparam int SW_W      = 8;
    localparam int LED_W     = 16;
    localparam int NUM_DIG   = 4;
    localparam int DB_TICK   = 4;
    localparam int SCAN_TICK = 2;
    localparam int RST_HOLD  = 3;

    localparam logic [7:0] HEX_TBL [16] = '{
        8'h7E, 8'h12, 8'hBC, 8'hB6, 8'hD2, 8'hE6, 8'hEE, 8'h32,
        8'hFE, 8'hF6, 8'hFA, 8'hCE, 8'h6C, 8'h9E, 8'hEC, 8'hE8
    };

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [31:0]          remote_switch;
    logic [SW_W-1:0]      local_switch;
    logic                 local_sw_chg;
    logic [LED_W-1:0]     local_leds;
    logic [LED_W-1:0]     remote_leds;
    logic                 remote_reset;
    logic                 local_resetn;
    logic [4*NUM_DIG-1:0] local_num_data;
    logic [NUM_DIG-1:0]   local_num_dp;
    logic                 local_num_we;
    logic [NUM_DIG-1:0]   remote_dig_sel;
    logic [7:0]           remote_seg;

    int checks = 0;
    int errors = 0;

    // Model of the accepted switch state
    logic [SW_W-1:0] model_sw = '0;

    remote_io_bridge #(
        .SW_W      (SW_W),
        .LED_W     (LED_W),
        .NUM_DIG   (NUM_DIG),
        .DB_TICK   (DB_TICK),
        .SCAN_TICK (SCAN_TICK),
        .RST_HOLD  (RST_HOLD)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .remote_switch  (remote_switch),
        .local_switch   (local_switch),
        .local_sw_chg   (local_sw_chg),
        .local_leds     (local_leds),
        .remote_leds    (remote_leds),
        .remote_reset   (remote_reset),
        .local_resetn   (local_resetn),
        .local_num_data (local_num_data),
        .local_num_dp   (local_num_dp),
        .local_num_we   (local_num_we),
        .remote_dig_sel (remote_dig_sel),
        .remote_seg     (remote_seg)
    );

    always #5 clk = ~clk;

    function automatic int sel_index(input logic [NUM_DIG-1:0] sel);
        for (int i = 0; i < NUM_DIG; i++) begin
            if (sel[i]) return i;
        end
        return 0;
    endfunction

    task automatic test_reset();
        resetn         = 1'b0;
        remote_switch  = '1;
        remote_reset   = 1'b0;
        local_leds     = 16'h1234;
        local_num_data = 16'hABCD;
        local_num_dp   = 4'hF;
        local_num_we   = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (local_switch !== '0) begin errors++; $display("[TB] FAIL reset_sw got %h want 00", local_switch); end
        checks++; if (local_sw_chg !== 1'b0) begin errors++; $display("[TB] FAIL reset_chg got %b want 0", local_sw_chg); end
        checks++; if (remote_leds !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_leds got %h want FFFF", remote_leds); end
        checks++; if (local_resetn !== 1'b0) begin errors++; $display("[TB] FAIL reset_resetn got %b want 0", local_resetn); end
        checks++; if (remote_dig_sel !== 4'b0001) begin errors++; $display("[TB] FAIL reset_dig_sel got %b want 0001", remote_dig_sel); end
        checks++; if (remote_seg !== 8'h7E) begin errors++; $display("[TB] FAIL reset_seg got %h want 7E", remote_seg); end
        local_num_we = 1'b0;
        local_num_data = '0;
        local_num_dp   = '0;
        resetn = 1'b1;
        // Power-on: no remote reset pending, so release after RST_HOLD cycles
        begin
            int first = -1;
            for (int k = 1; k <= RST_HOLD + 6; k++) begin
                @(negedge clk);
                if (first < 0 && local_resetn === 1'b1) first = k;
            end
            checks++; if (first !== RST_HOLD) begin errors++; $display("[TB] FAIL poweron_release got %0d want %0d", first, RST_HOLD); end
        end
    endtask

    // Apply a new raw switch word and check acceptance timing and a single pulse
    task automatic test_debounce_accept(input logic [31:0] raw, input string name);
        logic [SW_W-1:0] want;
        logic [SW_W-1:0] old;
        int first;
        int pulses;
        int pulse_at;
        want = ~raw[SW_W-1:0];
        old  = model_sw;
        first = -1; pulses = 0; pulse_at = -1;
        remote_switch = raw;
        for (int k = 1; k <= 2 + 2 * DB_TICK + 6; k++) begin
            @(negedge clk);
            if (local_sw_chg === 1'b1) begin pulses++; pulse_at = k; end
            if (first < 0 && local_switch === want) first = k;
            checks++;
            if (local_switch !== old && local_switch !== want) begin
                errors++; $display("[TB] FAIL %s_partial got %h want %h or %h", name, local_switch, old, want);
            end
        end
        checks++;
        if (first < 2 + DB_TICK || first > 2 + 2 * DB_TICK) begin
            errors++; $display("[TB] FAIL %s_latency got %0d want %0d..%0d", name, first, 2 + DB_TICK, 2 + 2 * DB_TICK);
        end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL %s_pulses got %0d want 1", name, pulses); end
        checks++; if (pulse_at !== first) begin errors++; $display("[TB] FAIL %s_pulse_align got %0d want %0d", name, pulse_at, first); end
        model_sw = want;
    endtask

    // A pulse shorter than DB_TICK on one switch must never be accepted
    task automatic test_debounce_glitch(input int bit_idx, input int len);
        logic [31:0] base;
        int pulses;
        int changed;
        base = remote_switch;
        pulses = 0; changed = 0;
        remote_switch[bit_idx] = ~base[bit_idx];
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (local_sw_chg === 1'b1) pulses++;
            if (local_switch !== model_sw) changed++;
        end
        remote_switch = base;
        for (int k = 0; k < 2 + 3 * DB_TICK; k++) begin
            @(negedge clk);
            if (local_sw_chg === 1'b1) pulses++;
            if (local_switch !== model_sw) changed++;
        end
        checks++; if (changed !== 0) begin errors++; $display("[TB] FAIL glitch_b%0d_l%0d_value got %0d changed cycles want 0", bit_idx, len, changed); end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL glitch_b%0d_l%0d_pulse got %0d want 0", bit_idx, len, pulses); end
    endtask

    task automatic test_debounce_random(input int n);
        logic [31:0] raw;
        for (int t = 0; t < n; t++) begin
            raw = $urandom;
            if (~raw[SW_W-1:0] == model_sw) raw[0] = ~raw[0];
            test_debounce_accept(raw, "db_rand");
            test_debounce_glitch($urandom_range(0, SW_W - 1), $urandom_range(1, DB_TICK - 1));
        end
    endtask

    task automatic test_leds();
        logic [LED_W-1:0] v;
        for (int t = 0; t < 6; t++) begin
            v = (t == 0) ? 16'h00A5 : LED_W'($urandom);
            local_leds = v;
            @(negedge clk);
            checks++; if (remote_leds !== ~v) begin errors++; $display("[TB] FAIL leds got %h want %h", remote_leds, ~v); end
        end
    endtask

    task automatic test_reset_stretch();
        int first;
        int early;
        checks++; if (local_resetn !== 1'b1) begin errors++; $display("[TB] FAIL stretch_idle got %b want 1", local_resetn); end
        remote_reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                checks++; if (local_resetn !== 1'b0) begin errors++; $display("[TB] FAIL stretch_hold_k%0d got %b want 0", k, local_resetn); end
            end
        end
        remote_reset = 1'b0;
        first = -1; early = 0;
        for (int k = 1; k <= 2 + RST_HOLD + 5; k++) begin
            @(negedge clk);
            if (first < 0 && local_resetn === 1'b1) first = k;
            if (first >= 0 && local_resetn !== 1'b1) early++;
        end
        checks++; if (first !== 2 + RST_HOLD) begin errors++; $display("[TB] FAIL stretch_release got %0d want %0d", first, 2 + RST_HOLD); end
        checks++; if (early !== 0) begin errors++; $display("[TB] FAIL stretch_glitch got %0d low cycles want 0", early); end
    endtask

    task automatic test_reset_restart();
        int first;
        remote_reset = 1'b1;
        repeat (4) @(negedge clk);
        remote_reset = 1'b0;
        // Two sync cycles plus one count cycle: hold count is now 1
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (local_resetn !== 1'b0) begin errors++; $display("[TB] FAIL restart_pre_k%0d got %b want 0", k, local_resetn); end
        end
        remote_reset = 1'b1;
        repeat (2) @(negedge clk);
        remote_reset = 1'b0;
        first = -1;
        for (int k = 1; k <= 2 + RST_HOLD + 5; k++) begin
            @(negedge clk);
            if (first < 0 && local_resetn === 1'b1) first = k;
        end
        checks++; if (first !== 2 + RST_HOLD) begin errors++; $display("[TB] FAIL restart_release got %0d want %0d", first, 2 + RST_HOLD); end
    endtask

    // Capture a value, scramble the inputs, then watch two full scans
    task automatic test_display_scan(input logic [15:0] data, input logic [3:0] dp, input string name);
        logic [NUM_DIG-1:0] prev_sel;
        logic [NUM_DIG-1:0] exp_next;
        logic [7:0] exp_seg;
        logic [3:0] nib;
        int run;
        int idx;
        int runs_seen;
        bit first_run;
        @(negedge clk);
        local_num_data = data;
        local_num_dp   = dp;
        local_num_we   = 1'b1;
        @(negedge clk);
        local_num_we   = 1'b0;
        local_num_data = 16'($urandom);
        local_num_dp   = 4'($urandom);
        @(negedge clk);
        prev_sel = remote_dig_sel; run = 1; first_run = 1; runs_seen = 0;
        for (int c = 0; c < 2 * NUM_DIG * SCAN_TICK + 2; c++) begin
            @(negedge clk);
            checks++;
            if (!$onehot(remote_dig_sel)) begin
                errors++; $display("[TB] FAIL %s_onehot got %b want one-hot", name, remote_dig_sel);
            end else begin
                idx = sel_index(remote_dig_sel);
                nib = data[4*idx +: 4];
                exp_seg = HEX_TBL[nib] | {7'b0, dp[idx]};
                checks++;
                if (remote_seg !== exp_seg) begin
                    errors++; $display("[TB] FAIL %s_seg_d%0d got %h want %h", name, idx, remote_seg, exp_seg);
                end
            end
            if (remote_dig_sel === prev_sel) begin
                run++;
            end else begin
                exp_next = {prev_sel[NUM_DIG-2:0], prev_sel[NUM_DIG-1]};
                checks++;
                if (remote_dig_sel !== exp_next) begin
                    errors++; $display("[TB] FAIL %s_order got %b want %b", name, remote_dig_sel, exp_next);
                end
                if (!first_run) begin
                    checks++;
                    if (run !== SCAN_TICK) begin
                        errors++; $display("[TB] FAIL %s_dwell got %0d want %0d", name, run, SCAN_TICK);
                    end
                end
                runs_seen++;
                first_run = 0; run = 1; prev_sel = remote_dig_sel;
            end
        end
        checks++; if (runs_seen < NUM_DIG) begin errors++; $display("[TB] FAIL %s_advance got %0d transitions want >=%0d", name, runs_seen, NUM_DIG); end
    endtask

    task automatic test_async_reset();
        int bad_seg;
        test_debounce_accept(32'hFFFF_FFC3, "pre_async");
        test_display_scan(16'h5A3C, 4'b1010, "pre_async_disp");
        checks++; if (local_switch !== 8'h3C) begin errors++; $display("[TB] FAIL async_pre_sw got %h want 3C", local_switch); end
        local_leds = 16'h0F0F;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if (local_switch !== '0) begin errors++; $display("[TB] FAIL async_sw got %h want 00", local_switch); end
        checks++; if (local_sw_chg !== 1'b0) begin errors++; $display("[TB] FAIL async_chg got %b want 0", local_sw_chg); end
        checks++; if (remote_leds !== 16'hFFFF) begin errors++; $display("[TB] FAIL async_leds got %h want FFFF", remote_leds); end
        checks++; if (local_resetn !== 1'b0) begin errors++; $display("[TB] FAIL async_resetn got %b want 0", local_resetn); end
        checks++; if (remote_dig_sel !== 4'b0001) begin errors++; $display("[TB] FAIL async_dig_sel got %b want 0001", remote_dig_sel); end
        checks++; if (remote_seg !== 8'h7E) begin errors++; $display("[TB] FAIL async_seg got %h want 7E", remote_seg); end
        @(negedge clk);
        resetn = 1'b1;
        model_sw = '0;
        @(negedge clk);
        checks++; if (local_switch !== '0) begin errors++; $display("[TB] FAIL async_post_sw got %h want 00", local_switch); end
        // Latched display value must have been cleared: every digit shows plain '0'
        bad_seg = 0;
        for (int c = 0; c < 2 * NUM_DIG * SCAN_TICK; c++) begin
            @(negedge clk);
            if (remote_seg !== 8'h7E) bad_seg++;
        end
        checks++; if (bad_seg !== 0) begin errors++; $display("[TB] FAIL async_latch_clear got %0d bad cycles want 0", bad_seg); end
    endtask

    initial begin
        $display("[TB] remote_io_bridge bench start");
        test_reset();
        repeat (3 * DB_TICK) @(negedge clk);
        test_debounce_accept(32'hFFFF_FFFE, "db_press0");
        test_debounce_glitch(0, 3);
        test_debounce_accept(32'hFFFF_FFFF, "db_release0");
        test_debounce_glitch(0, 3);
        test_debounce_random(6);
        test_leds();
        test_reset_stretch();
        test_reset_restart();
        test_display_scan(16'h1F80, 4'b0100, "disp_fixed");
        for (int t = 0; t < 4; t++) begin
            test_display_scan(16'($urandom), 4'($urandom), "disp_rand");
        end
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
